ifm_pkt_fifo: RTL
=================

# ifm_pkt_fifo

Single-clock, parametrised store-and-forward packet FIFO for the 10GbE receive path, sitting between the receive frame checker and the S2MM DMA in the `s2mm_clk` domain. It generalises the fixed-width good/ctrl FIFOs into one block with configurable data width and depth. It adds frame commit/drop: frames flagged bad at `tlast`, or frames that overflow, are rewound and never appear on the output. Upstream is never back-pressured; downstream sees only complete, good frames.

## Interface
- C_DATA_WIDTH, 64, stream data width; multiple of 8; keep width is C_DATA_WIDTH/8
- C_PTR_WIDTH, 10, depth = 2**C_PTR_WIDTH beats
- C_PROG_FULL_THRESH, 700, used-beat count at or above which prog_full asserts
- s2mm_clk  in  1  sole clock, rising edge
- s2mm_reset  in  1  asynchronous, active-high reset
- s_tdata  in  C_DATA_WIDTH  write beat data
- s_tkeep  in  C_DATA_WIDTH/8  byte enables
- s_tlast  in  1  last beat of frame
- s_tuser  in  1  bad-frame flag, sampled only with s_tlast
- s_tvalid  in  1  beat valid; no ready, always accepted
- m_tdata  out  C_DATA_WIDTH  read beat data
- m_tkeep  out  C_DATA_WIDTH/8  byte enables
- m_tlast  out  1  last beat
- m_tvalid  out  1  output register holds a beat
- m_tready  in  1  downstream accept
- prog_full  out  1  registered almost-full
- frame_cnt  out  C_PTR_WIDTH+1  committed frames not yet fully read
- good_cnt  out  32  frames committed (stats)
- drop_cnt  out  32  frames discarded (stats)

## Operation
- Pointers are C_PTR_WIDTH+1 bits:
  - wr_ptr: speculative write pointer.
  - wr_cmt: committed write pointer.
  - rd_ptr: read pointer.
- used = wr_ptr − rd_ptr (modulo 2**(C_PTR_WIDTH+1)). full = (used == 2**C_PTR_WIDTH).
- Write, per accepted beat:
  - If !full and !ovf: store {tlast, tkeep, tdata} at wr_ptr[C_PTR_WIDTH-1:0], then wr_ptr++.
  - If full: discard the beat and set ovf.
- Commit/drop on a beat with s_tlast:
  - Commit if s_tuser=0 and ovf=0 and the beat was stored: wr_cmt ← wr_ptr+1, frame_cnt++, good_cnt++.
  - Otherwise drop: wr_ptr ← wr_cmt, ovf ← 0, drop_cnt++.
- Frames longer than the depth are always dropped.
- Read: load the output register when rd_ptr != wr_cmt and (!m_tvalid or m_tready); rd_ptr++. Only committed beats are ever read.
- m_tvalid clears on handshake when no load happens in the same cycle.
- frame_cnt decrements on a handshake with m_tlast=1. A simultaneous commit and last-beat read leaves frame_cnt unchanged.
- Counters wrap modulo 2**32.
- Reset values: all pointers 0, ovf 0, m_tvalid 0, m_tdata/m_tkeep/m_tlast 0, prog_full 0, all counters 0. Reset mid-frame discards everything, including partially written frames.

## Timing
- A commit beat sampled at edge k updates wr_cmt at edge k. From empty, m_tvalid rises at edge k+1 with the first beat of the frame.
- With m_tready=1 held, throughput is one beat per clock with no bubbles inside or between committed frames.
- prog_full is registered from the post-update used count: 1 cycle of latency.
- Drop rewind takes effect at the tlast edge. A new frame's first beat in the next cycle writes at the rewound wr_ptr.
- Pointer wrap is handled by the extra MSB; full and empty are never ambiguous.

## Configuration
- IFM_PKT_FIFO_STATS_EN defined: good_cnt and drop_cnt are live 32-bit counters.
- Not defined: the counter logic is removed, good_cnt and drop_cnt are tied to 0, and the ports remain.
- frame_cnt is always present.

## Structure
- Shared package ifm_pkg:
  - IFM_STAT_W = 32.
  - A beat-entry width function, C_DATA_WIDTH + C_DATA_WIDTH/8 + 1.
  - A pointer-difference helper.
- Sub-module ifm_sdp_ram: single-clock simple dual-port RAM, width and depth parameters, registered read port with read enable. Its read register serves as the output data register.

## Test plan
- 8-beat good frame into empty FIFO (C_DATA_WIDTH=64), m_tready=1 -> m_tvalid rises 1 cycle after the tlast edge; 8 consecutive beats; tkeep of last beat preserved (e.g. 8'h0F); good_cnt=1, frame_cnt returns to 0.
- Good 4-beat frame, then bad 6-beat frame (s_tuser=1), then good 3-beat frame, all back-to-back -> output is exactly 4+3 beats; drop_cnt=1, good_cnt=2.
- C_PTR_WIDTH=4, m_tready=0, 20-beat frame -> frame dropped, used returns to the pre-frame value, a following 5-beat frame is committed and read intact.
- Fill to C_PROG_FULL_THRESH-1 then 1 beat (THRESH=10, depth 16) -> prog_full asserts the cycle after the 10th beat's edge and deasserts 1 cycle after used drops to 9.
- Commit edge coincides with the m_tlast handshake of the previous frame -> frame_cnt unchanged; random m_tready with 200 random frames -> scoreboard matches all good frames, none of the bad ones.
- Assert s2mm_reset mid-frame with 2 frames committed -> m_tvalid=0 immediately, counters 0, and the next frame after release is output alone.

Source files
------------

// File: rtl/ifm_pkg.sv
// Shared definitions for the ifm packet FIFO: statistics counter width,
// beat-entry width (data + keep + last) and a modulo pointer subtraction.
package ifm_pkg;

    localparam int IFM_STAT_W = 32;

    // Width of one stored beat: {tlast, tkeep, tdata}.
    function automatic int ifm_entry_w(input int data_w);
        return data_w + data_w / 8 + 1;
    endfunction

    // (a - b) modulo 2**ptr_w; pointers carry an extra wrap bit so that
    // a full buffer and an empty one give different differences.
    function automatic logic [31:0] ifm_ptr_diff(input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input int          ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/ifm_sdp_ram.sv
// Single-clock simple dual-port RAM. The read port is registered with an
// enable; the read register is reset so it can double as an output stage.
module ifm_sdp_ram #(
    parameter int WIDTH  = 73,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port: storage array is not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port; holds its value while rd_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ifm_pkt_fifo.sv
// Store-and-forward packet FIFO for the 10GbE receive path (s2mm_clk).
// Beats are written speculatively; a frame becomes readable only once its
// tlast beat arrives good and unoverflowed. Bad or overflowed frames are
// rewound to the last commit point and never reach the output.
// Define IFM_PKT_FIFO_STATS_EN to enable the good/drop frame counters;
// without it good_cnt/drop_cnt read as zero.
import ifm_pkg::*;

module ifm_pkt_fifo #(
    parameter int C_DATA_WIDTH       = 64,
    parameter int C_PTR_WIDTH        = 10,
    parameter int C_PROG_FULL_THRESH = 700
) (
    input  logic                      s2mm_clk,
    input  logic                      s2mm_reset,
    input  logic [C_DATA_WIDTH-1:0]   s_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                      s_tlast,
    input  logic                      s_tuser,
    input  logic                      s_tvalid,
    output logic [C_DATA_WIDTH-1:0]   m_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_tkeep,
    output logic                      m_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      prog_full,
    output logic [C_PTR_WIDTH:0]      frame_cnt,
    output logic [IFM_STAT_W-1:0]     good_cnt,
    output logic [IFM_STAT_W-1:0]     drop_cnt
);

    localparam int             KEEP_W = C_DATA_WIDTH / 8;
    localparam int             ENT_W  = ifm_entry_w(C_DATA_WIDTH);
    localparam int             PW     = C_PTR_WIDTH + 1;
    localparam logic [PW-1:0]  ONE    = PW'(1);
    localparam logic [PW-1:0]  DEPTH  = PW'(2 ** C_PTR_WIDTH);
    localparam logic [PW-1:0]  THRESH = PW'(C_PROG_FULL_THRESH);

    logic [PW-1:0] wr_ptr, wr_cmt, rd_ptr;
    logic [PW-1:0] wr_ptr_nxt, wr_cmt_nxt, rd_ptr_nxt;
    logic [PW-1:0] used, used_nxt;
    logic          ovf, ovf_nxt;
    logic          full, wr_store, commit, drop, load, last_hs;
    logic [ENT_W-1:0] rd_ent;

    assign used     = PW'(ifm_ptr_diff(32'(wr_ptr), 32'(rd_ptr), PW));
    assign full     = (used == DEPTH);
    // A beat is stored only while there is room and the frame is still clean.
    assign wr_store = s_tvalid && !full && !ovf;
    // The tlast beat itself must have been stored for the frame to survive.
    assign commit   = s_tvalid && s_tlast && !s_tuser && wr_store;
    assign drop     = s_tvalid && s_tlast && !commit;
    // Only committed beats are visible to the read side.
    assign load     = (rd_ptr != wr_cmt) && (!m_tvalid || m_tready);
    assign last_hs  = m_tvalid && m_tready && m_tlast;

    // Next-state pointers; prog_full is derived from their post-update values.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        wr_cmt_nxt = wr_cmt;
        rd_ptr_nxt = rd_ptr;
        ovf_nxt    = ovf;
        if (drop) begin
            wr_ptr_nxt = wr_cmt;
            ovf_nxt    = 1'b0;
        end else begin
            if (wr_store)         wr_ptr_nxt = wr_ptr + ONE;
            if (s_tvalid && full) ovf_nxt    = 1'b1;
        end
        if (commit) wr_cmt_nxt = wr_ptr + ONE;
        if (load)   rd_ptr_nxt = rd_ptr + ONE;
        used_nxt = PW'(ifm_ptr_diff(32'(wr_ptr_nxt), 32'(rd_ptr_nxt), PW));
    end

    // Pointer, overflow and almost-full state.
    always_ff @(posedge s2mm_clk or posedge s2mm_reset) begin
        if (s2mm_reset) begin
            wr_ptr    <= '0;
            wr_cmt    <= '0;
            rd_ptr    <= '0;
            ovf       <= 1'b0;
            prog_full <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            wr_cmt    <= wr_cmt_nxt;
            rd_ptr    <= rd_ptr_nxt;
            ovf       <= ovf_nxt;
            prog_full <= (used_nxt >= THRESH);
        end
    end

    // Output valid: set on load, cleared by a handshake with nothing to reload.
    always_ff @(posedge s2mm_clk or posedge s2mm_reset) begin
        if (s2mm_reset)    m_tvalid <= 1'b0;
        else if (load)     m_tvalid <= 1'b1;
        else if (m_tready) m_tvalid <= 1'b0;
    end

    // Committed-but-unread frames; commit and last-beat read cancel out.
    always_ff @(posedge s2mm_clk or posedge s2mm_reset) begin
        if (s2mm_reset) begin
            frame_cnt <= '0;
        end else begin
            case ({commit, last_hs})
                2'b10:   frame_cnt <= frame_cnt + ONE;
                2'b01:   frame_cnt <= frame_cnt - ONE;
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

    // Beat storage; the RAM read register is the output data register.
    ifm_sdp_ram #(
        .WIDTH  (ENT_W),
        .ADDR_W (C_PTR_WIDTH)
    ) u_ram (
        .clk     (s2mm_clk),
        .rst     (s2mm_reset),
        .wr_en   (wr_store),
        .wr_addr (wr_ptr[C_PTR_WIDTH-1:0]),
        .wr_data ({s_tlast, s_tkeep, s_tdata}),
        .rd_en   (load),
        .rd_addr (rd_ptr[C_PTR_WIDTH-1:0]),
        .rd_data (rd_ent)
    );

    assign m_tdata = rd_ent[C_DATA_WIDTH-1:0];
    assign m_tkeep = rd_ent[C_DATA_WIDTH +: KEEP_W];
    assign m_tlast = rd_ent[ENT_W-1];

`ifdef IFM_PKT_FIFO_STATS_EN
    // Frame statistics, free-running modulo 2**32.
    always_ff @(posedge s2mm_clk or posedge s2mm_reset) begin
        if (s2mm_reset) begin
            good_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (commit) good_cnt <= good_cnt + 1'b1;
            if (drop)   drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign good_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule
